// File: rtl/morse_key_number_encoder.sv
// Times presses on a Morse key, classifies dot/dash and decodes a character to a 4-bit value.
// Define MORSE_HEX_LETTERS_EN to also accept the letters A-F (values 10-15).
module morse_key_number_encoder #(
  parameter int CNT_W      = 16,
  parameter int MIN_PRESS  = 2,
  parameter int DOT_MAX    = 4,
  parameter int GAP_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       timeout,
  output logic [3:0] number,
  output logic       number_valid,
  output logic       error,
  output logic [2:0] sym_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRESS  = 2'd1,
    S_GAP    = 2'd2,
    S_DECODE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] MIN_PRESS_C = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] DOT_MAX_C   = CNT_W'(DOT_MAX);
  // Gap counter already includes the low cycle seen in PRESS, so expiry is one short.
  localparam logic [CNT_W-1:0] GAP_LAST_C  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       SYM_MAX     = 3'd5;

  logic             key_meta_q;
  logic             key_s_q;
  state_t           state_q,     state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic [4:0]       pattern_q,   pattern_d;
  logic [2:0]       sym_count_q, sym_count_d;
  logic             overflow_q,  overflow_d;
  logic [3:0]       number_q,    number_d;
  logic             valid_q,     valid_d;
  logic             error_q,     error_d;

  logic             dec_hit;
  logic [3:0]       dec_val;
  logic             is_dash;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
    end else begin
      key_meta_q <= key_in;
      key_s_q    <= key_meta_q;
    end
  end

  // Pattern holds only the captured symbols (upper bits zero), so length+bits is a unique key.
  always_comb begin
    dec_hit = 1'b1;
    dec_val = 4'd0;
    case ({sym_count_q, pattern_q})
      {3'd5, 5'b11111}: dec_val = 4'd0;
      {3'd5, 5'b01111}: dec_val = 4'd1;
      {3'd5, 5'b00111}: dec_val = 4'd2;
      {3'd5, 5'b00011}: dec_val = 4'd3;
      {3'd5, 5'b00001}: dec_val = 4'd4;
      {3'd5, 5'b00000}: dec_val = 4'd5;
      {3'd5, 5'b10000}: dec_val = 4'd6;
      {3'd5, 5'b11000}: dec_val = 4'd7;
      {3'd5, 5'b11100}: dec_val = 4'd8;
      {3'd5, 5'b11110}: dec_val = 4'd9;
`ifdef MORSE_HEX_LETTERS_EN
      {3'd2, 5'b00001}: dec_val = 4'd10;
      {3'd4, 5'b01000}: dec_val = 4'd11;
      {3'd4, 5'b01010}: dec_val = 4'd12;
      {3'd3, 5'b00100}: dec_val = 4'd13;
      {3'd1, 5'b00000}: dec_val = 4'd14;
      {3'd4, 5'b00010}: dec_val = 4'd15;
`endif
      default:          dec_hit = 1'b0;
    endcase
  end

  assign is_dash = (press_cnt_q > DOT_MAX_C);

  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pattern_d   = pattern_q;
    sym_count_d = sym_count_q;
    overflow_d  = overflow_q;
    number_d    = number_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;

    if (timeout) begin
      state_d     = S_IDLE;
      pattern_d   = 5'd0;
      sym_count_d = 3'd0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_s_q) begin
            state_d     = S_PRESS;
            press_cnt_d = CNT_ONE;
          end
        end
        S_PRESS: begin
          if (key_s_q) begin
            if (press_cnt_q != CNT_MAX) press_cnt_d = press_cnt_q + CNT_ONE;
          end else if (press_cnt_q < MIN_PRESS_C) begin
            state_d   = (sym_count_q != 3'd0) ? S_GAP : S_IDLE;
            gap_cnt_d = CNT_ONE;
          end else begin
            if (sym_count_q == SYM_MAX) begin
              overflow_d = 1'b1;
            end else begin
              pattern_d   = {pattern_q[3:0], is_dash};
              sym_count_d = sym_count_q + 3'd1;
            end
            state_d   = S_GAP;
            gap_cnt_d = CNT_ONE;
          end
        end
        S_GAP: begin
          if (key_s_q) begin
            state_d     = S_PRESS;
            press_cnt_d = CNT_ONE;
          end else if (gap_cnt_q >= GAP_LAST_C) begin
            state_d = S_DECODE;
          end else if (gap_cnt_q != CNT_MAX) begin
            gap_cnt_d = gap_cnt_q + CNT_ONE;
          end
        end
        S_DECODE: begin
          if (dec_hit && !overflow_q) begin
            number_d = dec_val;
            valid_d  = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          pattern_d   = 5'd0;
          sym_count_d = 3'd0;
          overflow_d  = 1'b0;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      pattern_q   <= 5'd0;
      sym_count_q <= 3'd0;
      overflow_q  <= 1'b0;
      number_q    <= 4'd0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pattern_q   <= pattern_d;
      sym_count_q <= sym_count_d;
      overflow_q  <= overflow_d;
      number_q    <= number_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign error        = error_q;
  assign sym_count    = sym_count_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/morse_key_number_encoder.md
# morse_key_number_encoder

Keyer-side counterpart of the number-to-Morse display path. It times presses on a single Morse key and classifies each press as dot or dash. It accumulates up to five symbols per character and, after an inter-character gap, encodes the pattern back into a 4-bit value (digits 0–9, optionally hex letters A–F). It sits between the debounced key button and game control, which compares the returned number against the prompted one.

## Interface
- CNT_W, 16, width of press/gap counters; counters saturate at 2^CNT_W-1
- MIN_PRESS, 2, presses shorter than this many cycles are glitches and are ignored
- DOT_MAX, 4, a press of 1..DOT_MAX cycles (after glitch filter) is a dot; longer is a dash
- GAP_CYCLES, 10, consecutive key-low cycles that close a character; DOT_MAX < GAP_CYCLES < 2^CNT_W
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_in  in  1  debounced key level, 1 = pressed; asynchronous to clk
- timeout  in  1  game-control round timeout; aborts the current character
- number  out  4  last successfully encoded value; held until the next success
- number_valid  out  1  one-cycle pulse, number updated this cycle
- error  out  1  one-cycle pulse, pattern unmatched or more than 5 symbols
- sym_count  out  3  symbols captured in current character (0..5, saturates at 5)
- busy  out  1  high whenever state != IDLE

One clock; reset is asynchronous and active-high.

## Operation
- key_in passes through a 2-flop synchronizer to key_s. All logic uses key_s.
- Symbol register: 5 bits, 1 = dash, 0 = dot. The first keyed symbol is the MSB of the used length.
- Reset values: number=0, number_valid=0, error=0, sym_count=0, busy=0, state IDLE, pattern/overflow cleared.
- IDLE: on key_s=1, go to PRESS and clear the press counter to 1.
- PRESS: increment while key_s=1. On key_s=0:
  - count < MIN_PRESS: glitch; go to GAP if sym_count>0, else IDLE; no symbol is recorded.
  - Otherwise: classify the press and shift it in. If sym_count is already 5, set the sticky overflow flag instead. Go to GAP with the gap counter cleared.
- GAP: increment while key_s=0. On key_s=1, go to PRESS. When GAP_CYCLES consecutive low cycles have elapsed, go to DECODE.
- DECODE (1 cycle): match {sym_count, pattern}.
  - Digits: 0 -----, 1 .----, 2 ..---, 3 ...--, 4 ....-, 5 ....., 6 -...., 7 --..., 8 ---.., 9 ----.
  - On match with no overflow: load number and pulse number_valid. Otherwise pulse error and hold number.
  - Clear pattern, sym_count and overflow; go to IDLE.
- timeout=1 in any state: go to IDLE next cycle, clear pattern, sym_count and overflow. No number_valid or error pulse.

## Timing
- Key-to-logic latency: 2 cycles (synchronizer).
- number_valid/error assert in the cycle after DECODE, coinciding with busy=0.
- Counting from the first key_s=0 cycle after the last press, the pulse appears GAP_CYCLES+1 cycles later.
- Gap expiry and key_s=1 in the same cycle: the press wins; go to PRESS and the character continues.
- timeout has priority over all other transitions, including DECODE; a pulse pending from DECODE is suppressed.
- rst mid-character: outputs drop to reset values immediately; no pulse follows deassertion.
- Press counter saturates; a held key remains one dash. The gap counter saturates likewise.
- number_valid and error are never high in the same cycle.

## Configuration
- MORSE_HEX_LETTERS_EN defined: additionally decode A .- =10, B -... =11, C -.-. =12, D -.. =13, E . =14, F ..-. =15.
- Not defined: these patterns pulse error; only the ten 5-symbol digit patterns succeed.

## Test plan
Bench parameters: MIN_PRESS=2, DOT_MAX=4, GAP_CYCLES=10.
- Press pattern 3,3,8,8,8 cycles with 3-cycle gaps, then 12 idle -> number=2, number_valid one cycle, sym_count returns to 0.
- Presses of exactly 4 and 5 cycles, then gap -> pattern ".-". With MORSE_HEX_LETTERS_EN: number=10. Without: error pulse, number unchanged.
- Six dot presses then gap -> error pulse, no number_valid. A following valid "-----" -> number=0.
- 1-cycle key blip between valid dots of "....." -> ignored; number=5, sym_count peaks at 5.
- timeout pulse after 3 symbols -> busy=0 next cycle, sym_count=0, no pulse ever emitted.
- rst asserted during PRESS of "-...." -> all outputs 0 asynchronously; after release, "--..." -> number=7.
